// File: rtl/data_mem_slave_pkg.sv
// Shared widths and FSM encoding for the CPU data-memory responder.
package data_mem_slave_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;
endpackage

// File: rtl/data_mem_slave_if.sv
// CPU data-memory bus: strobe/ack handshake with word address and 16-bit data.
interface data_mem_slave_if;
  import data_mem_slave_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              stb;
  logic              we;
  logic              ack;
  logic              err;

  modport master (output addr, wr_data, stb, we, input rd_data, ack, err);
  modport slave  (input addr, wr_data, stb, we, output rd_data, ack, err);
endinterface

// File: rtl/dmem_ram.sv
// DEPTH x 16 single-port store: synchronous write, registered read (old data on collision).
module dmem_ram
  import data_mem_slave_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/data_mem_slave.sv
// Data-memory responder: latches a strobed request, waits WAIT_STATES cycles, then
// acks for one cycle; out-of-range accesses ack with err, drop writes and read zero.
module data_mem_slave
  import data_mem_slave_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int AW          = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  data_mem_slave_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [DATA_W-1:0] hold_q;

  logic              idle;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              cur_we;
  logic              cur_in_range;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rd_now;
  logic              rd_ack;

  // In IDLE the bus is live (zero-wait requests go straight to ACK on the sampling
  // edge); afterwards the latched copy is used so bus changes are ignored.
  assign idle         = (state_q == IDLE);
  assign cur_addr     = idle ? bus.addr    : addr_q;
  assign cur_wdata    = idle ? bus.wr_data : wdata_q;
  assign cur_we       = idle ? bus.we      : we_q;
  assign cur_in_range = (cur_addr < ADDR_W'(DEPTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.stb) begin
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ACK;
          end
        end
      end
      WAIT: begin
        if (!bus.stb) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ram_we = (state_d == ACK) && (state_q != ACK) && cur_we && cur_in_range;

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (sys_clk),
    .we    (ram_we),
    .addr  (cur_addr[AW-1:0]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (idle && bus.stb) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wr_data;
        we_q    <= bus.we;
      end
      if (rd_ack) hold_q <= rd_now;
    end
  end

  // Registered RAM output is valid in ACK; hold_q keeps it until the next read ack.
  assign rd_ack      = (state_q == ACK) && !we_q;
  assign rd_now      = cur_in_range ? ram_rdata : '0;
  assign bus.rd_data = rd_ack ? rd_now : hold_q;
  assign bus.ack     = (state_q == ACK);
  assign bus.err     = (state_q == ACK) && !cur_in_range;
endmodule

// File: tb/tb_data_mem_slave.sv
// Bench for data_mem_slave: three instances (WAIT_STATES 1, 0, 3) against a transaction-level memory model.
module tb_data_mem_slave;
  localparam int ND    = 3;
  localparam int DEPTH = 256;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  logic [15:0] b_addr  [ND];
  logic [15:0] b_wdata [ND];
  logic        b_stb   [ND];
  logic        b_we    [ND];

  data_mem_slave_if bus0 ();
  data_mem_slave_if bus1 ();
  data_mem_slave_if bus2 ();

  assign bus0.addr = b_addr[0]; assign bus0.wr_data = b_wdata[0];
  assign bus0.stb  = b_stb[0];  assign bus0.we      = b_we[0];
  assign bus1.addr = b_addr[1]; assign bus1.wr_data = b_wdata[1];
  assign bus1.stb  = b_stb[1];  assign bus1.we      = b_we[1];
  assign bus2.addr = b_addr[2]; assign bus2.wr_data = b_wdata[2];
  assign bus2.stb  = b_stb[2];  assign bus2.we      = b_we[2];

  data_mem_slave #(.DEPTH(DEPTH), .AW(8), .WAIT_STATES(1)) u0 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus0));
  data_mem_slave #(.DEPTH(DEPTH), .AW(8), .WAIT_STATES(0)) u1 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus1));
  data_mem_slave #(.DEPTH(DEPTH), .AW(8), .WAIT_STATES(3)) u2 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus2));

  int tests_run = 0;
  int fails     = 0;

  // Reference: per-instance word memory, which words hold defined data, last read value.
  logic [15:0] mem     [ND][DEPTH];
  bit          known   [ND][DEPTH];
  logic [15:0] last_rd [ND];

  function automatic int ws_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic logic ack_of(input int d);
    case (d)
      0:       return bus0.ack;
      1:       return bus1.ack;
      default: return bus2.ack;
    endcase
  endfunction

  function automatic logic err_of(input int d);
    case (d)
      0:       return bus0.err;
      1:       return bus1.err;
      default: return bus2.err;
    endcase
  endfunction

  function automatic logic [15:0] rd_of(input int d);
    case (d)
      0:       return bus0.rd_data;
      1:       return bus1.rd_data;
      default: return bus2.rd_data;
    endcase
  endfunction

  function automatic void model_write(input int d, input logic [15:0] a, input logic [15:0] wd);
    if (a < 16'(DEPTH)) begin
      mem[d][a[7:0]]   = wd;
      known[d][a[7:0]] = 1'b1;
    end
  endfunction

  function automatic logic [15:0] model_read(input int d, input logic [15:0] a);
    return (a < 16'(DEPTH)) ? mem[d][a[7:0]] : 16'h0000;
  endfunction

  // Drives one request; drop_after>0 releases stb after that many cycles if no ack came.
  task automatic txn(input int d, input bit we, input logic [15:0] a, input logic [15:0] wd,
                     input int drop_after, output bit got, output int lat, output logic e,
                     output logic [15:0] rd, output logic ack_after);
    got = 1'b0; lat = 0; e = 1'b0; rd = 16'h0; ack_after = 1'b0;
    @(negedge sys_clk);
    b_addr[d] = a; b_wdata[d] = wd; b_we[d] = we; b_stb[d] = 1'b1;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(posedge sys_clk); #1;
      if (ack_of(d) === 1'b1) begin
        got = 1'b1; lat = c; e = err_of(d); rd = rd_of(d);
        b_stb[d] = 1'b0;
      end else if (drop_after > 0 && c >= drop_after) begin
        b_stb[d] = 1'b0;
      end
    end
    b_stb[d] = 1'b0;
    b_addr[d] = 16'($urandom);
    b_wdata[d] = 16'($urandom);
    @(posedge sys_clk); #1;
    ack_after = ack_of(d);
  endtask

  task automatic test_reset();
    #1;
    for (int d = 0; d < ND; d++) begin
      tests_run++;
      if (ack_of(d) !== 1'b0 || err_of(d) !== 1'b0 || rd_of(d) !== 16'h0000) begin
        fails++;
        $display("FAIL reset d=%0d ack=%b err=%b rd=%h need 0/0/0000", d, ack_of(d), err_of(d), rd_of(d));
      end
    end
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_ws1_basic();
    bit got; int lat; logic e; logic [15:0] rd; logic aa;
    txn(0, 1'b1, 16'h0005, 16'hBEEF, 0, got, lat, e, rd, aa);
    tests_run++;
    if (!got || lat != 2 || e !== 1'b0 || aa !== 1'b0 || rd !== last_rd[0]) begin
      fails++;
      $display("FAIL ws1_write got=%0d lat=%0d err=%b ack_after=%b rd=%h need 1/2/0/0/%h", got, lat, e, aa, rd, last_rd[0]);
    end
    model_write(0, 16'h0005, 16'hBEEF);
    txn(0, 1'b0, 16'h0005, 16'h0000, 0, got, lat, e, rd, aa);
    tests_run++;
    if (!got || lat != 2 || e !== 1'b0 || aa !== 1'b0 || rd !== 16'hBEEF) begin
      fails++;
      $display("FAIL ws1_read got=%0d lat=%0d err=%b ack_after=%b rd=%h need 1/2/0/0/beef", got, lat, e, aa, rd);
    end
    last_rd[0] = 16'hBEEF;
    txn(0, 1'b1, 16'h0006, 16'h1111, 0, got, lat, e, rd, aa);
    model_write(0, 16'h0006, 16'h1111);
    tests_run++;
    if (rd !== 16'hBEEF || rd_of(0) !== 16'hBEEF) begin
      fails++;
      $display("FAIL write_keeps_rd rd_at_ack=%h rd_now=%h need beef", rd, rd_of(0));
    end
  endtask

  task automatic test_async_reset();
    bit got; int lat; logic e; logic [15:0] rd; logic aa;
    @(posedge sys_clk); #3;
    sys_rst = 1'b1;
    #1;
    tests_run++;
    if (rd_of(0) !== 16'h0000 || ack_of(0) !== 1'b0 || err_of(0) !== 1'b0) begin
      fails++;
      $display("FAIL async_reset rd=%h ack=%b err=%b need 0000/0/0", rd_of(0), ack_of(0), err_of(0));
    end
    for (int d = 0; d < ND; d++) last_rd[d] = 16'h0000;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    txn(0, 1'b0, 16'h0005, 16'h0000, 0, got, lat, e, rd, aa);
    tests_run++;
    if (!got || rd !== 16'hBEEF || e !== 1'b0) begin
      fails++;
      $display("FAIL ram_survives_reset got=%0d rd=%h err=%b need 1/beef/0", got, rd, e);
    end
    last_rd[0] = 16'hBEEF;
  endtask

  // stb stays high across the ack; the request is re-purposed to a read while in ACK.
  task automatic test_back_to_back();
    logic [15:0] a, wd;
    int first, second;
    for (int d = 0; d < 2; d++) begin
      a  = (d == 1) ? 16'h0010 : 16'($urandom_range(0, 255));
      wd = (d == 1) ? 16'h1234 : 16'($urandom);
      first = 0; second = 0;
      @(negedge sys_clk);
      b_addr[d] = a; b_wdata[d] = wd; b_we[d] = 1'b1; b_stb[d] = 1'b1;
      for (int c = 1; c <= 30 && second == 0; c++) begin
        @(posedge sys_clk); #1;
        if (ack_of(d) === 1'b1) begin
          if (first == 0) begin
            first = c;
            b_we[d] = 1'b0;
          end else begin
            second = c;
            tests_run++;
            if (rd_of(d) !== wd || err_of(d) !== 1'b0) begin
              fails++;
              $display("FAIL b2b_data d=%0d rd=%h err=%b need %h/0", d, rd_of(d), err_of(d), wd);
            end
            b_stb[d] = 1'b0;
          end
        end
      end
      b_stb[d] = 1'b0;
      tests_run++;
      if (first != ws_of(d) + 1 || second - first != ws_of(d) + 2) begin
        fails++;
        $display("FAIL b2b_spacing d=%0d first=%0d gap=%0d need %0d/%0d", d, first, second - first, ws_of(d) + 1, ws_of(d) + 2);
      end
      model_write(d, a, wd);
      last_rd[d] = wd;
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic test_abort();
    bit got; int lat; logic e; logic [15:0] rd; logic aa;
    txn(2, 1'b1, 16'h0020, 16'h0000, 0, got, lat, e, rd, aa);
    model_write(2, 16'h0020, 16'h0000);
    txn(2, 1'b1, 16'h0020, 16'hAAAA, 2, got, lat, e, rd, aa);
    tests_run++;
    if (got || aa !== 1'b0) begin
      fails++;
      $display("FAIL abort_no_ack got=%0d lat=%0d need no ack", got, lat);
    end
    txn(2, 1'b0, 16'h0020, 16'h0000, 0, got, lat, e, rd, aa);
    tests_run++;
    if (!got || lat != 4 || rd !== 16'h0000) begin
      fails++;
      $display("FAIL abort_read got=%0d lat=%0d rd=%h need 1/4/0000", got, lat, rd);
    end
    last_rd[2] = 16'h0000;
  endtask

  task automatic test_out_of_range();
    bit got; int lat; logic e; logic [15:0] rd; logic aa;
    txn(0, 1'b1, 16'h0000, 16'h0A0A, 0, got, lat, e, rd, aa);
    model_write(0, 16'h0000, 16'h0A0A);
    txn(0, 1'b1, 16'h0100, 16'hFFFF, 0, got, lat, e, rd, aa);
    tests_run++;
    if (!got || lat != 2 || e !== 1'b1) begin
      fails++;
      $display("FAIL oor_write got=%0d lat=%0d err=%b need 1/2/1", got, lat, e);
    end
    txn(0, 1'b0, 16'h0000, 16'h0000, 0, got, lat, e, rd, aa);
    tests_run++;
    if (rd !== 16'h0A0A || e !== 1'b0) begin
      fails++;
      $display("FAIL oor_no_alias rd=%h err=%b need 0a0a/0", rd, e);
    end
    txn(0, 1'b0, 16'h0100, 16'h0000, 0, got, lat, e, rd, aa);
    tests_run++;
    if (!got || rd !== 16'h0000 || e !== 1'b1 || aa !== 1'b0) begin
      fails++;
      $display("FAIL oor_read got=%0d rd=%h err=%b need 1/0000/1", got, rd, e);
    end
    txn(0, 1'b0, 16'h00FF, 16'h0000, 0, got, lat, e, rd, aa);
    tests_run++;
    if (!got || e !== 1'b0) begin
      fails++;
      $display("FAIL top_in_range got=%0d err=%b need 1/0", got, e);
    end
    last_rd[0] = rd;
  endtask

  task automatic test_wait_ignore();
    bit got; int lat; logic e; logic [15:0] rd; logic aa;
    txn(2, 1'b1, 16'h0031, 16'h2468, 0, got, lat, e, rd, aa);
    model_write(2, 16'h0031, 16'h2468);
    @(negedge sys_clk);
    b_addr[2] = 16'h0030; b_wdata[2] = 16'h1357; b_we[2] = 1'b1; b_stb[2] = 1'b1;
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(posedge sys_clk); #1;
      if (c == 1) begin
        b_addr[2] = 16'h0031; b_wdata[2] = 16'hDEAD; b_we[2] = 1'b0;
      end
      if (ack_of(2) === 1'b1) begin
        got = 1'b1;
        b_stb[2] = 1'b0;
      end
    end
    b_stb[2] = 1'b0;
    model_write(2, 16'h0030, 16'h1357);
    txn(2, 1'b0, 16'h0030, 16'h0000, 0, got, lat, e, rd, aa);
    tests_run++;
    if (rd !== 16'h1357) begin
      fails++;
      $display("FAIL wait_ignore_a rd=%h need 1357", rd);
    end
    txn(2, 1'b0, 16'h0031, 16'h0000, 0, got, lat, e, rd, aa);
    tests_run++;
    if (rd !== 16'h2468) begin
      fails++;
      $display("FAIL wait_ignore_b rd=%h need 2468", rd);
    end
    last_rd[2] = 16'h2468;
  endtask

  task automatic test_reset_mid_wait();
    bit got; int lat; logic e; logic [15:0] rd; logic aa;
    bit seen;
    txn(2, 1'b1, 16'h0007, 16'h1111, 0, got, lat, e, rd, aa);
    model_write(2, 16'h0007, 16'h1111);
    txn(2, 1'b0, 16'h0007, 16'h0000, 0, got, lat, e, rd, aa);
    @(negedge sys_clk);
    b_addr[2] = 16'h0007; b_wdata[2] = 16'h5555; b_we[2] = 1'b1; b_stb[2] = 1'b1;
    @(posedge sys_clk); #2;
    sys_rst = 1'b1;
    #1;
    tests_run++;
    if (ack_of(2) !== 1'b0 || rd_of(2) !== 16'h0000 || err_of(2) !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_wait ack=%b rd=%h err=%b need 0/0000/0", ack_of(2), rd_of(2), err_of(2));
    end
    b_stb[2] = 1'b0;
    for (int d = 0; d < ND; d++) last_rd[d] = 16'h0000;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge sys_clk); #1;
      if (ack_of(2) === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (seen) begin
      fails++;
      $display("FAIL rst_no_late_ack saw ack=1 need 0");
    end
    txn(2, 1'b0, 16'h0007, 16'h0000, 0, got, lat, e, rd, aa);
    tests_run++;
    if (!got || rd !== 16'h1111) begin
      fails++;
      $display("FAIL rst_write_lost got=%0d rd=%h need 1/1111", got, rd);
    end
    last_rd[2] = 16'h1111;
  endtask

  task automatic test_random();
    bit got; int lat; logic e; logic [15:0] rd; logic aa;
    for (int n = 0; n < 60; n++) begin
      int          d   = $urandom_range(0, ND - 1);
      bit          we  = 1'($urandom_range(0, 1));
      logic [15:0] a   = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(256, 65535))
                                                     : 16'($urandom_range(0, 255));
      logic [15:0] wd  = 16'($urandom);
      logic        xer;
      logic [15:0] xrd;
      if (!we && a < 16'(DEPTH) && !known[d][a[7:0]]) we = 1'b1;
      xer = (a >= 16'(DEPTH));
      xrd = we ? last_rd[d] : model_read(d, a);
      txn(d, we, a, wd, 0, got, lat, e, rd, aa);
      tests_run++;
      if (!got || lat != ws_of(d) + 1 || e !== xer || rd !== xrd || aa !== 1'b0) begin
        fails++;
        $display("FAIL random n=%0d d=%0d we=%0d a=%h got=%0d lat=%0d err=%b rd=%h ack_after=%b need lat=%0d err=%b rd=%h",
                 n, d, we, a, got, lat, e, rd, aa, ws_of(d) + 1, xer, xrd);
      end
      if (we) model_write(d, a, wd);
      else    last_rd[d] = xrd;
    end
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      b_addr[d] = 16'h0; b_wdata[d] = 16'h0; b_stb[d] = 1'b0; b_we[d] = 1'b0;
      last_rd[d] = 16'h0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[d][i]   = 16'h0;
        known[d][i] = 1'b0;
      end
    end
    test_reset();
    test_ws1_basic();
    test_async_reset();
    test_back_to_back();
    test_abort();
    test_out_of_range();
    test_wait_ignore();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
